// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and helpers for the two-port RAM arbiter.
//   size_t     - access size encoding (byte/half/word; 2'b11 is illegal)
//   state_t    - arbiter FSM state (IDLE: no response pending, RESP: response pending)
//   misaligned - flags an illegal size or an offset that does not suit the size
package ram_arb_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_t;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  // Error if the size is illegal or the byte offset breaks natural alignment.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    logic err;
    case (size)
      SZ_B:    err = 1'b0;
      SZ_H:    err = off[0];
      SZ_W:    err = (off != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/store_merge.sv
// store_merge: combinational sub-word store merge.
//   i_old   - current RAM word (combinational read data)
//   i_wdata - right-aligned store data
//   i_size  - access size (size_t encoding)
//   i_off   - byte offset within the word
//   o_new   - word to write back: selected lanes from i_wdata, the rest from i_old
module store_merge
  import ram_arb_pkg::*;
(
  input  logic [31:0] i_old,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_off,
  output logic [31:0] o_new
);

  always_comb begin
    o_new = i_old;
    case (i_size)
      SZ_B:    o_new[8*i_off +: 8] = i_wdata[7:0];
      SZ_H:    o_new[16*i_off[1] +: 16] = i_wdata[15:0];
      SZ_W:    o_new = i_wdata;
      // Illegal size never writes, so the merged value does not matter.
      default: o_new = i_old;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter sharing one single-port data RAM between
// port 0 (core load/store unit) and port 1 (loader/debug master).
//   CLK, RSTn              - clock, asynchronous active-low reset
//   pN_valid/ready         - request handshake (N = 0, 1)
//   pN_we/size/addr/wdata  - request: store flag, size, byte address, right-aligned data
//   pN_rvalid/rready       - registered, back-pressurable response handshake
//   pN_rdata/rerr          - pre-access RAM word, misalignment/illegal-size flag
//   mem_we/addr/wdata      - to RAM (synchronous write)
//   mem_rdata              - from RAM (combinational read)
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_WORDS = 1024,
  parameter int unsigned DATA_W     = 32,
  localparam int unsigned WA        = $clog2(ADDR_WORDS)
) (
  input  logic              CLK,
  input  logic              RSTn,

  input  logic              p0_valid,
  output logic              p0_ready,
  input  logic              p0_we,
  input  logic [1:0]        p0_size,
  input  logic [WA+1:0]     p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_rvalid,
  input  logic              p0_rready,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_rerr,

  input  logic              p1_valid,
  output logic              p1_ready,
  input  logic              p1_we,
  input  logic [1:0]        p1_size,
  input  logic [WA+1:0]     p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_rvalid,
  input  logic              p1_rready,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_rerr,

  output logic              mem_we,
  output logic [WA-1:0]     mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            r_state;
  logic              r_own;
  logic              r_rr_last;
  logic [1:0]        r_rvalid;
  logic [1:0]        r_rerr;
  logic [DATA_W-1:0] r_rdata [2];

  logic              w_grant;
  logic              w_any;
  logic              w_own_done;
  logic              w_can_accept;
  logic              w_accept;
  logic              w_we;
  logic [1:0]        w_size;
  logic [WA+1:0]     w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_err;
  logic [1:0]        w_rready;

  assign w_rready = {p1_rready, p0_rready};

  // Grant: lone requester wins; on contention the port that did not win last time.
  // With nothing valid the grant rests on port 0 so mem_addr follows port 0.
  always_comb begin
    w_any = p0_valid | p1_valid;
    if (p0_valid && p1_valid) begin
      w_grant = ~r_rr_last;
    end else begin
      w_grant = p1_valid;
    end
  end

  always_comb begin
    if (w_grant) begin
      w_we    = p1_we;
      w_size  = p1_size;
      w_addr  = p1_addr;
      w_wdata = p1_wdata;
    end else begin
      w_we    = p0_we;
      w_size  = p0_size;
      w_addr  = p0_addr;
      w_wdata = p0_wdata;
    end
  end

  assign w_err        = misaligned(w_size, w_addr[1:0]);
  assign w_own_done   = r_rvalid[r_own] & w_rready[r_own];
  assign w_can_accept = (r_state == IDLE) | w_own_done;
  // RSTn gating keeps ready and the RAM write low for the whole reset, including
  // a reset that lands mid-transaction.
  assign w_accept     = RSTn & w_can_accept & w_any;

  assign p0_ready  = RSTn & w_can_accept & ~w_grant;
  assign p1_ready  = RSTn & w_can_accept & w_grant;

  assign mem_addr  = w_addr[WA+1:2];
  assign mem_we    = w_accept & w_we & ~w_err;

  store_merge u_store_merge (
    .i_old   (mem_rdata),
    .i_wdata (w_wdata),
    .i_size  (w_size),
    .i_off   (w_addr[1:0]),
    .o_new   (mem_wdata)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state    <= IDLE;
      r_own      <= 1'b0;
      r_rr_last  <= 1'b1;
      r_rvalid   <= 2'b00;
      r_rerr     <= 2'b00;
      r_rdata[0] <= '0;
      r_rdata[1] <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (r_rvalid[n] && w_rready[n]) begin
          r_rvalid[n] <= 1'b0;
        end
      end
      if (w_accept) begin
        // Later assignment overrides the consume-clear when the owner wins again.
        r_rvalid[w_grant] <= 1'b1;
        r_rdata[w_grant]  <= mem_rdata;
        r_rerr[w_grant]   <= w_err;
        r_own             <= w_grant;
        r_rr_last         <= w_grant;
        r_state           <= RESP;
      end else if (w_own_done) begin
        r_state <= IDLE;
      end
    end
  end

  assign p0_rvalid = r_rvalid[0];
  assign p1_rvalid = r_rvalid[1];
  assign p0_rdata  = r_rdata[0];
  assign p1_rdata  = r_rdata[1];
  assign p0_rerr   = r_rerr[0];
  assign p1_rerr   = r_rerr[1];

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed self-checking bench for ram_arbiter with a behavioural RAM.
module tb_ram_arbiter;

  localparam int unsigned AW = 1024;
  localparam int unsigned WA = 10;

  logic          CLK;
  logic          RSTn;
  logic          p0_valid, p0_ready, p0_we, p0_rvalid, p0_rready, p0_rerr;
  logic [1:0]    p0_size;
  logic [WA+1:0] p0_addr;
  logic [31:0]   p0_wdata, p0_rdata;
  logic          p1_valid, p1_ready, p1_we, p1_rvalid, p1_rready, p1_rerr;
  logic [1:0]    p1_size;
  logic [WA+1:0] p1_addr;
  logic [31:0]   p1_wdata, p1_rdata;
  logic          mem_we;
  logic [WA-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  logic [31:0]   ram [AW];
  logic          tb_we;
  logic [WA-1:0] tb_waddr;
  logic [31:0]   tb_wdata;

  int n_checks;
  int n_errors;

  ram_arbiter #(.ADDR_WORDS(AW), .DATA_W(32)) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .p0_valid  (p0_valid),
    .p0_ready  (p0_ready),
    .p0_we     (p0_we),
    .p0_size   (p0_size),
    .p0_addr   (p0_addr),
    .p0_wdata  (p0_wdata),
    .p0_rvalid (p0_rvalid),
    .p0_rready (p0_rready),
    .p0_rdata  (p0_rdata),
    .p0_rerr   (p0_rerr),
    .p1_valid  (p1_valid),
    .p1_ready  (p1_ready),
    .p1_we     (p1_we),
    .p1_size   (p1_size),
    .p1_addr   (p1_addr),
    .p1_wdata  (p1_wdata),
    .p1_rvalid (p1_rvalid),
    .p1_rready (p1_rready),
    .p1_rdata  (p1_rdata),
    .p1_rerr   (p1_rerr),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural RAM: combinational read, synchronous write; tb_we preloads contents.
  assign mem_rdata = ram[mem_addr];
  always @(posedge CLK) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    else if (tb_we) ram[tb_waddr] <= tb_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [WA-1:0] a, input logic [31:0] d);
    @(negedge CLK);
    tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
    @(posedge CLK); #1;
    tb_we = 1'b0;
  endtask

  task automatic idle_inputs();
    p0_valid = 0; p0_we = 0; p0_size = 2'b10; p0_addr = '0; p0_wdata = '0; p0_rready = 1;
    p1_valid = 0; p1_we = 0; p1_size = 2'b10; p1_addr = '0; p1_wdata = '0; p1_rready = 1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RSTn = 1'b0;
    idle_inputs();
    #1;
    check("rst_p0_ready", {31'b0, p0_ready}, 32'd0);
    check("rst_p1_ready", {31'b0, p1_ready}, 32'd0);
    @(negedge CLK);
    RSTn = 1'b1;
  endtask

  task automatic drive(input bit p, input logic we, input logic [1:0] sz,
                       input logic [WA+1:0] a, input logic [31:0] wd);
    if (p) begin
      p1_valid = 1; p1_we = we; p1_size = sz; p1_addr = a; p1_wdata = wd;
    end else begin
      p0_valid = 1; p0_we = we; p0_size = sz; p0_addr = a; p0_wdata = wd;
    end
  endtask

  // One lone request on port p: checks the accept-cycle RAM controls, then the response.
  task automatic xact(input string tag, input bit p, input logic we, input logic [1:0] sz,
                      input logic [WA+1:0] a, input logic [31:0] wd, input logic exp_we,
                      input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                      input logic exp_err);
    @(negedge CLK);
    drive(p, we, sz, a, wd);
    #1;
    check({tag, "_ready"}, {31'b0, (p ? p1_ready : p0_ready)}, 32'd1);
    check({tag, "_mem_addr"}, {22'b0, mem_addr}, {22'b0, a[WA+1:2]});
    check({tag, "_mem_we"}, {31'b0, mem_we}, {31'b0, exp_we});
    if (exp_we) check({tag, "_mem_wdata"}, mem_wdata, exp_wdata);
    @(posedge CLK); #1;
    p0_valid = 0; p1_valid = 0;
    check({tag, "_rvalid"}, {31'b0, (p ? p1_rvalid : p0_rvalid)}, 32'd1);
    check({tag, "_rdata"}, (p ? p1_rdata : p0_rdata), exp_rdata);
    check({tag, "_rerr"}, {31'b0, (p ? p1_rerr : p0_rerr)}, {31'b0, exp_err});
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    RSTn     = 1'b0;
    tb_we    = 1'b0;
    tb_waddr = '0;
    tb_wdata = '0;
    idle_inputs();

    preload(10'd0, 32'h0BAD_CAFE);
    preload(10'd1, 32'hA1B2_C3D4);
    preload(10'd2, 32'hDEAD_BEEF);
    preload(10'd3, 32'h1122_3344);
    preload(10'd4, 32'h4444_4444);
    preload(10'd5, 32'h5555_5555);

    // Reset state
    do_reset();
    #1;
    check("rst_p0_rvalid", {31'b0, p0_rvalid}, 32'd0);
    check("rst_p1_rvalid", {31'b0, p1_rvalid}, 32'd0);
    check("rst_p0_rdata", p0_rdata, 32'd0);
    check("rst_p1_rerr", {31'b0, p1_rerr}, 32'd0);

    // 1: load; 2: byte store merge into lane 1
    xact("load", 1'b0, 1'b0, 2'b10, 12'h008, 32'h0, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0);
    xact("stb", 1'b0, 1'b1, 2'b00, 12'h00D, 32'h0000_00AB, 1'b1, 32'h1122_AB44,
         32'h1122_3344, 1'b0);
    check("stb_ram", ram[3], 32'h1122_AB44);

    // 3: continuous contention alternates grants starting with port 0
    do_reset();
    @(negedge CLK);
    drive(1'b0, 1'b0, 2'b10, 12'h010, 32'h0);
    drive(1'b1, 1'b0, 2'b10, 12'h014, 32'h0);
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("rr%0d_p0_ready", k), {31'b0, p0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("rr%0d_p1_ready", k), {31'b0, p1_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
      @(posedge CLK); #1;
      check($sformatf("rr%0d_p0_rvalid", k), {31'b0, p0_rvalid},
            (k % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("rr%0d_p1_rvalid", k), {31'b0, p1_rvalid},
            (k % 2 == 1) ? 32'd1 : 32'd0);
      check($sformatf("rr%0d_rdata", k), (k % 2 == 0) ? p0_rdata : p1_rdata,
            (k % 2 == 0) ? 32'h4444_4444 : 32'h5555_5555);
      @(negedge CLK);
    end
    p0_valid = 0; p1_valid = 0;

    // 4: error cases never write; then a legal upper-half store
    xact("sth_mis", 1'b1, 1'b1, 2'b01, 12'h003, 32'h0000_BEEF, 1'b0, 32'h0, 32'h0BAD_CAFE,
         1'b1);
    xact("sz11", 1'b1, 1'b0, 2'b11, 12'h004, 32'h0, 1'b0, 32'h0, 32'hA1B2_C3D4, 1'b1);
    xact("ldw_mis", 1'b1, 1'b0, 2'b10, 12'h006, 32'h0, 1'b0, 32'h0, 32'hA1B2_C3D4, 1'b1);
    check("err_ram0", ram[0], 32'h0BAD_CAFE);
    xact("sth_hi", 1'b1, 1'b1, 2'b01, 12'h006, 32'h0000_BEEF, 1'b1, 32'hBEEF_C3D4,
         32'hA1B2_C3D4, 1'b0);
    check("sth_ram1", ram[1], 32'hBEEF_C3D4);

    // 5: back-pressure on port 0 holds the response and blocks port 1
    @(negedge CLK);
    p0_rready = 0;
    drive(1'b0, 1'b0, 2'b10, 12'h008, 32'h0);
    @(posedge CLK); #1;
    p0_valid = 0;
    drive(1'b1, 1'b0, 2'b10, 12'h00C, 32'h0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp%0d_p0_rvalid", k), {31'b0, p0_rvalid}, 32'd1);
      check($sformatf("bp%0d_p0_rdata", k), p0_rdata, 32'hDEAD_BEEF);
      check($sformatf("bp%0d_p1_ready", k), {31'b0, p1_ready}, 32'd0);
      @(posedge CLK); #1;
    end
    @(negedge CLK);
    p0_rready = 1;
    #1;
    check("bp_p1_ready_rise", {31'b0, p1_ready}, 32'd1);
    @(posedge CLK); #1;
    p1_valid = 0;
    check("bp_p1_rvalid", {31'b0, p1_rvalid}, 32'd1);
    check("bp_p1_rdata", p1_rdata, 32'h1122_AB44);
    check("bp_p0_rvalid", {31'b0, p0_rvalid}, 32'd0);

    // 6: reset during RESP drops the response and blocks the pending store
    @(negedge CLK);
    p0_rready = 0;
    drive(1'b0, 1'b0, 2'b10, 12'h008, 32'h0);
    @(posedge CLK); #1;
    p0_valid = 0;
    drive(1'b1, 1'b1, 2'b10, 12'h000, 32'hCAFE_F00D);
    check("mr_p0_rvalid_pre", {31'b0, p0_rvalid}, 32'd1);
    #2;
    RSTn = 1'b0;
    #1;
    check("mr_p0_rvalid", {31'b0, p0_rvalid}, 32'd0);
    check("mr_mem_we", {31'b0, mem_we}, 32'd0);
    check("mr_p1_ready", {31'b0, p1_ready}, 32'd0);
    @(posedge CLK); #1;
    check("mr_ram0", ram[0], 32'h0BAD_CAFE);
    @(negedge CLK);
    RSTn = 1'b1;
    p0_rready = 1;
    drive(1'b0, 1'b0, 2'b10, 12'h008, 32'h0);
    #1;
    check("mr_post_p0_ready", {31'b0, p0_ready}, 32'd1);
    check("mr_post_p1_ready", {31'b0, p1_ready}, 32'd0);
    @(posedge CLK); #1;
    p0_valid = 0; p1_valid = 0;
    check("mr_post_p0_rdata", p0_rdata, 32'hDEAD_BEEF);

    repeat (2) @(posedge CLK);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
